// File: rtl/spk_pack_pkg.sv
// Shared parameters, payload types and helpers for the spike packer.
//   trig_t : queued trigger {channel, frame, neighbour list}
//   fsm_t  : packet sequencer states
package spk_pack_pkg;

    localparam int unsigned NUM_CH   = 160;
    localparam int unsigned CH_W     = 8;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned GRP      = 4;
    localparam int unsigned PRE      = 8;
    localparam int unsigned POST     = 10;
    localparam int unsigned DEPTH    = 32;
    localparam int unsigned TQ_DEPTH = 16;
    localparam int unsigned REFRACT  = 19;

    localparam int unsigned SPK_LEN  = PRE + 1 + POST;
    localparam int unsigned FR_AW    = $clog2(DEPTH);
    localparam int unsigned TQ_AW    = $clog2(TQ_DEPTH);
    localparam int unsigned RAM_AW   = $clog2(DEPTH * NUM_CH);
    localparam int unsigned BEAT_W   = GRP * DATA_W;
    localparam int unsigned GRP_W    = GRP * CH_W;
    localparam int unsigned K_W      = $clog2(SPK_LEN + 1);

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [31:0]      frame;
        logic [GRP_W-1:0] grp;
    } trig_t;

    typedef enum logic [1:0] {IDLE, WAIT, READ} fsm_t;

    // Flat ring address: frame slot major, channel minor.
    function automatic logic [RAM_AW-1:0] ram_addr(input logic [FR_AW-1:0] slot,
                                                   input logic [CH_W-1:0]  ch);
        return RAM_AW'(slot) * RAM_AW'(NUM_CH) + RAM_AW'(ch);
    endfunction

endpackage

// File: rtl/spk_trig_fifo.sv
// Synchronous trigger FIFO with registered head output.
//   clk, rst        : clock, synchronous active-high reset
//   push, din       : enqueue (ignored when full unless popping the same cycle)
//   pop             : dequeue head (ignored when empty)
//   dout            : current head entry, valid while !empty
//   full, empty     : registered occupancy flags
module spk_trig_fifo
    import spk_pack_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  trig_t din,
    input  logic  pop,
    output trig_t dout,
    output logic  full,
    output logic  empty
);

    localparam int unsigned CNT_W = TQ_AW + 1;

    trig_t            mem [TQ_DEPTH];
    logic [TQ_AW-1:0] wr_ptr;
    logic [TQ_AW-1:0] rd_ptr;
    logic [TQ_AW-1:0] rd_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot, so push on full is accepted when popping.
    always_comb begin
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        rd_nxt    = rd_ptr + TQ_AW'(1);
        count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage array, no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, flags and the registered head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            dout   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + TQ_AW'(1);
            if (do_pop)  rd_ptr <= rd_nxt;
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(TQ_DEPTH));
            empty <= (count_nxt == '0);
            if (do_pop) begin
                dout <= (count >= CNT_W'(2)) ? mem[rd_nxt] : din;
            end else if (empty && do_push) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/spk_packer_n.sv
// Spike packer: caches the muap sample stream in a DEPTH-frame ring and, for
// each queued trigger, streams a SPK_LEN-beat packet of GRP neighbour channels
// covering frames trig-PRE .. trig+POST.
//   clk, rst                  : clock, synchronous active-high reset
//   valid_in, frame_no_in,
//   ch_in, v_in, grp_in,
//   trig_in                   : sample stream with optional trigger
//   spk_tvalid/tready/tdata/
//   tch/tframe/tlast          : AXI-stream packet output
//   spk_pulse                 : one pulse per packet, cycle after first beat handshake
//   drop_cnt                  : saturating count of lost triggers
// Build option: SPK_PACK_REFRACT_EN adds a per-channel refractory filter.
module spk_packer_n
    import spk_pack_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [31:0]         frame_no_in,
    input  logic [CH_W-1:0]     ch_in,
    input  logic [DATA_W-1:0]   v_in,
    input  logic [GRP_W-1:0]    grp_in,
    input  logic                trig_in,
    output logic                spk_tvalid,
    input  logic                spk_tready,
    output logic [BEAT_W-1:0]   spk_tdata,
    output logic [CH_W-1:0]     spk_tch,
    output logic [31:0]         spk_tframe,
    output logic                spk_tlast,
    output logic                spk_pulse,
    output logic [15:0]         drop_cnt
);

    fsm_t               state;
    trig_t              head;
    trig_t              push_data;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic               push_req, refr_block, drop_full;
    logic               seen, done_vld;
    logic [31:0]        prev_frame, first_frame, done_frame;
    logic               wr_en;
    logic [RAM_AW-1:0]  wr_addr;
    logic [K_W-1:0]     rd_k;
    logic [31:0]        rd_frame;
    logic               before_first;
    logic               issue, q_move, hs, tlast_hs, wait_done, stale;
    logic               q_vld, q_last, q_first, out_first;
    logic [GRP-1:0]     issue_zero, q_zero;
    logic [BEAT_W-1:0]  ram_word, out_word;
    logic [1:0]         drop_inc;
    logic [16:0]        drop_sum;

    // Frame bookkeeping: first frame seen and last completed frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen        <= 1'b0;
            done_vld    <= 1'b0;
            prev_frame  <= '0;
            first_frame <= '0;
            done_frame  <= '0;
        end else if (valid_in) begin
            seen       <= 1'b1;
            prev_frame <= frame_no_in;
            if (!seen) begin
                first_frame <= frame_no_in;
            end else if (frame_no_in != prev_frame) begin
                done_frame <= prev_frame;
                done_vld   <= 1'b1;
            end
        end
    end

`ifdef SPK_PACK_REFRACT_EN
    logic [31:0]       last_fr [NUM_CH];
    logic [NUM_CH-1:0] last_vld;
    logic              ch_ok;
    logic [CH_W-1:0]   ch_idx;
    logic              push_ok;

    always_comb begin
        ch_ok      = ch_in < CH_W'(NUM_CH);
        ch_idx     = ch_ok ? ch_in : '0;
        refr_block = ch_ok && last_vld[ch_idx] &&
                     ((frame_no_in - last_fr[ch_idx]) < 32'(REFRACT));
        push_ok    = push_req && ch_ok && (!fifo_full || fifo_pop);
    end

    // Last accepted trigger frame per channel.
    always_ff @(posedge clk) begin
        if (push_ok) last_fr[ch_idx] <= frame_no_in;
    end

    always_ff @(posedge clk) begin
        if (rst)          last_vld <= '0;
        else if (push_ok) last_vld[ch_idx] <= 1'b1;
    end
`else
    assign refr_block = 1'b0;
`endif

    // Handshakes, read issue, WAIT release and drop accounting.
    always_comb begin
        wr_en        = valid_in && (ch_in < CH_W'(NUM_CH));
        wr_addr      = ram_addr(frame_no_in[FR_AW-1:0], ch_in);
        push_req     = valid_in && trig_in && !refr_block;
        push_data    = trig_t'{ch: ch_in, frame: frame_no_in, grp: grp_in};
        hs           = spk_tvalid && spk_tready;
        tlast_hs     = hs && spk_tlast;
        q_move       = q_vld && (!spk_tvalid || spk_tready);
        issue        = (state == READ) && (rd_k < K_W'(SPK_LEN)) && (!q_vld || q_move);
        rd_frame     = head.frame - 32'(PRE) + 32'(rd_k);
        before_first = $signed(rd_frame - first_frame) < $signed(32'd0);
        wait_done    = (state == WAIT) && done_vld &&
                       ($signed(done_frame - head.frame) >= $signed(32'(POST)));
        stale        = $signed(frame_no_in - head.frame) > $signed(32'(DEPTH - POST - 2));
        fifo_pop     = tlast_hs || (wait_done && stale);
        drop_full    = push_req && fifo_full && !fifo_pop;
        drop_inc     = 2'(drop_full) + 2'(wait_done && stale);
        drop_sum     = {1'b0, drop_cnt} + 17'(drop_inc);
    end

    spk_trig_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   (push_data),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // One ring copy per lane, all written with the same sample stream.
    for (genvar i = 0; i < GRP; i++) begin : g_lane
        localparam int unsigned LO_CH = (GRP - 1 - i) * CH_W;
        localparam int unsigned LO_D  = (GRP - 1 - i) * DATA_W;

        logic [DATA_W-1:0] mem [DEPTH * NUM_CH];
        logic [DATA_W-1:0] q;
        logic [CH_W-1:0]   nn;
        logic              nn_ok;
        logic [RAM_AW-1:0] rd_addr;

        assign nn            = head.grp[LO_CH +: CH_W];
        assign nn_ok         = nn < CH_W'(NUM_CH);
        assign rd_addr       = ram_addr(rd_frame[FR_AW-1:0], nn_ok ? nn : '0);
        assign issue_zero[i] = !nn_ok || before_first;
        assign ram_word[LO_D +: DATA_W] = q;

        // q only advances on issue, so it doubles as the one-beat skid.
        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_addr] <= v_in;
            if (issue) q <= mem[rd_addr];
        end
    end

    // Zero lanes for invalid neighbours or frames before the stream began.
    always_comb begin
        out_word = ram_word;
        for (int i = 0; i < GRP; i++) begin
            if (q_zero[i]) out_word[(GRP - 1 - i) * DATA_W +: DATA_W] = '0;
        end
    end

    // Sequencer, read pipeline and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_k       <= '0;
            q_vld      <= 1'b0;
            q_last     <= 1'b0;
            q_first    <= 1'b0;
            q_zero     <= '0;
            out_first  <= 1'b0;
            spk_tvalid <= 1'b0;
            spk_tdata  <= '0;
            spk_tch    <= '0;
            spk_tframe <= '0;
            spk_tlast  <= 1'b0;
            spk_pulse  <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            spk_pulse <= hs && out_first;
            drop_cnt  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

            if (issue) begin
                rd_k    <= rd_k + K_W'(1);
                q_vld   <= 1'b1;
                q_zero  <= issue_zero;
                q_last  <= (rd_k == K_W'(SPK_LEN - 1));
                q_first <= (rd_k == '0);
            end else if (q_move) begin
                q_vld <= 1'b0;
            end

            if (q_move) begin
                spk_tvalid <= 1'b1;
                spk_tdata  <= out_word;
                spk_tch    <= head.ch;
                spk_tframe <= head.frame;
                spk_tlast  <= q_last;
                out_first  <= q_first;
            end else if (hs) begin
                spk_tvalid <= 1'b0;
                spk_tlast  <= 1'b0;
            end

            case (state)
                IDLE: if (!fifo_empty) state <= WAIT;
                WAIT: begin
                    if (wait_done) begin
                        if (stale) begin
                            state <= IDLE;
                        end else begin
                            state <= READ;
                            rd_k  <= '0;
                        end
                    end
                end
                READ: if (tlast_hs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spk_packer_n.sv
// Directed self-checking bench for spk_packer_n. Samples are v = frame*1000+ch
// for channels 0..9 of every frame; packets are collected by a monitor and
// compared beat by beat against expected frame/neighbour values.
module tb_spk_packer_n;

    localparam int NUM_CH  = 160;
    localparam int PRE     = 8;
    localparam int SPK_LEN = 19;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_in = 1'b0;
    logic [31:0]  frame_no_in = '0;
    logic [7:0]   ch_in = '0;
    logic [31:0]  v_in = '0;
    logic [31:0]  grp_in = '0;
    logic         trig_in = 1'b0;
    logic         spk_tvalid;
    logic         spk_tready;
    logic [127:0] spk_tdata;
    logic [7:0]   spk_tch;
    logic [31:0]  spk_tframe;
    logic         spk_tlast;
    logic         spk_pulse;
    logic [15:0]  drop_cnt;

    typedef struct {
        logic [127:0] d;
        logic [7:0]   c;
        logic [31:0]  f;
        logic         l;
    } beat_t;

    beat_t q_beats[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    pulse_cnt = 0;
    int    stall_err = 0;
    int    fr = 0;
    int    first_fr = 0;
    logic  rand_ready = 1'b0;
    logic  ready_force = 1'b1;

    spk_packer_n dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .frame_no_in (frame_no_in),
        .ch_in       (ch_in),
        .v_in        (v_in),
        .grp_in      (grp_in),
        .trig_in     (trig_in),
        .spk_tvalid  (spk_tvalid),
        .spk_tready  (spk_tready),
        .spk_tdata   (spk_tdata),
        .spk_tch     (spk_tch),
        .spk_tframe  (spk_tframe),
        .spk_tlast   (spk_tlast),
        .spk_pulse   (spk_pulse),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    // Output monitor: drives tready, records accepted beats, checks stall stability.
    initial begin
        beat_t prev_b;
        logic  prev_stall;
        prev_stall = 1'b0;
        prev_b     = '{d: '0, c: '0, f: '0, l: 1'b0};
        spk_tready = 1'b0;
        forever begin
            @(negedge clk);
            spk_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (spk_pulse) pulse_cnt++;
                if (prev_stall && (spk_tvalid !== 1'b1 || spk_tdata !== prev_b.d ||
                                   spk_tch !== prev_b.c || spk_tframe !== prev_b.f ||
                                   spk_tlast !== prev_b.l))
                    stall_err++;
                prev_b = '{d: spk_tdata, c: spk_tch, f: spk_tframe, l: spk_tlast};
                if (spk_tvalid && spk_tready) q_beats.push_back(prev_b);
                prev_stall = spk_tvalid && !spk_tready;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_lane(input int f, input int nn);
        if (nn >= NUM_CH || f < first_fr) return 32'd0;
        return 32'(f * 1000 + nn);
    endfunction

    function automatic logic [127:0] exp_word(input int f, input logic [31:0] grp);
        logic [127:0] w;
        logic [7:0]   nn;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            nn = grp[(3 - i) * 8 +: 8];
            w[(3 - i) * 32 +: 32] = exp_lane(f, int'(nn));
        end
        return w;
    endfunction

    task automatic send_sample(input int f, input int ch, input logic trig, input logic [31:0] grp);
        @(negedge clk);
        valid_in    = 1'b1;
        frame_no_in = 32'(f);
        ch_in       = 8'(ch);
        v_in        = 32'(f * 1000 + ch);
        trig_in     = trig;
        grp_in      = grp;
    endtask

    task automatic stream_to(input int last);
        for (int f = fr; f <= last; f++)
            for (int ch = 0; ch < 10; ch++) send_sample(f, ch, 1'b0, 32'd0);
        fr = last + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_in = 1'b0;
            trig_in  = 1'b0;
        end
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int cyc;
        cyc = 0;
        while (q_beats.size() < n && cyc < budget) begin
            idle(1);
            cyc++;
        end
        n_checks++;
        if (q_beats.size() < n) begin
            n_fail++;
            $display("FAIL %s timeout: beats got %0d need %0d", tag, q_beats.size(), n);
        end
    endtask

    task automatic expect_packet(input int tc, input int tf, input logic [31:0] grp, input string tag);
        beat_t b;
        for (int k = 0; k < SPK_LEN; k++) begin
            n_checks++;
            if (q_beats.size() == 0) begin
                n_fail++;
                $display("FAIL %s beat %0d missing", tag, k);
                return;
            end
            b = q_beats.pop_front();
            if (b.d !== exp_word(tf - PRE + k, grp)) begin
                n_fail++;
                $display("FAIL %s beat %0d tdata got %h exp %h", tag, k, b.d, exp_word(tf - PRE + k, grp));
            end
            n_checks++;
            if (b.c !== 8'(tc)) begin
                n_fail++;
                $display("FAIL %s beat %0d tch got %0d exp %0d", tag, k, b.c, tc);
            end
            n_checks++;
            if (b.f !== 32'(tf)) begin
                n_fail++;
                $display("FAIL %s beat %0d tframe got %0d exp %0d", tag, k, b.f, tf);
            end
            n_checks++;
            if (b.l !== (k == SPK_LEN - 1)) begin
                n_fail++;
                $display("FAIL %s beat %0d tlast got %b exp %b", tag, k, b.l, (k == SPK_LEN - 1));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (spk_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset tvalid got %b exp 0", spk_tvalid); end
        n_checks++; if (spk_tlast !== 1'b0) begin n_fail++; $display("FAIL reset tlast got %b exp 0", spk_tlast); end
        n_checks++; if (spk_pulse !== 1'b0) begin n_fail++; $display("FAIL reset pulse got %b exp 0", spk_pulse); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset drop_cnt got %0d exp 0", drop_cnt); end
        n_checks++; if (spk_tdata !== 128'd0) begin n_fail++; $display("FAIL reset tdata got %h exp 0", spk_tdata); end
        n_checks++; if (spk_tch !== 8'd0) begin n_fail++; $display("FAIL reset tch got %0d exp 0", spk_tch); end
        n_checks++; if (spk_tframe !== 32'd0) begin n_fail++; $display("FAIL reset tframe got %0d exp 0", spk_tframe); end
        rst = 1'b0;
        fr = 0;
        first_fr = 0;
    endtask

    task automatic test_first_frame();
        logic [31:0] g;
        g = {8'd5, 8'd6, 8'd7, 8'd200};
        stream_to(3);
        send_sample(3, 5, 1'b1, g);
        stream_to(14);
        wait_beats(SPK_LEN, 400, "first_frame");
        expect_packet(5, 3, g, "first_frame");
        n_checks++;
        if (pulse_cnt !== 1) begin n_fail++; $display("FAIL first_frame pulses got %0d exp 1", pulse_cnt); end
    endtask

    task automatic test_ramp();
        logic [31:0] g;
        g = {8'd5, 8'd6, 8'd7, 8'd200};
        stream_to(40);
        send_sample(40, 5, 1'b1, g);
        stream_to(51);
        wait_beats(SPK_LEN, 400, "ramp");
        expect_packet(5, 40, g, "ramp");
        idle(5);
        n_checks++;
        if (pulse_cnt !== 2) begin n_fail++; $display("FAIL ramp pulses got %0d exp 2", pulse_cnt); end
        n_checks++;
        if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL ramp drop_cnt got %0d exp 0", drop_cnt); end
    endtask

    function automatic logic [31:0] ovf_grp(input int i);
        return {8'(i % 10), 8'((i + 3) % 10), 8'(200 + i), 8'((i * 7) % 10)};
    endfunction

    task automatic test_fifo_overflow();
        stream_to(60);
        for (int i = 0; i < 17; i++) send_sample(60, 10 + i, 1'b1, ovf_grp(i));
        stream_to(71);
        wait_beats(16 * SPK_LEN, 3000, "overflow");
        for (int i = 0; i < 16; i++) expect_packet(10 + i, 60, ovf_grp(i), "overflow");
        idle(60);
        n_checks++;
        if (q_beats.size() !== 0) begin n_fail++; $display("FAIL overflow extra beats got %0d exp 0", q_beats.size()); end
        n_checks++;
        if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL overflow drop_cnt got %0d exp 1", drop_cnt); end
        n_checks++;
        if (pulse_cnt !== 18) begin n_fail++; $display("FAIL overflow pulses got %0d exp 18", pulse_cnt); end
    endtask

    task automatic test_backpressure();
        logic [31:0] g1, g2;
        g1 = {8'd1, 8'd2, 8'd3, 8'd4};
        g2 = {8'd8, 8'd9, 8'd170, 8'd0};
        rand_ready = 1'b1;
        stream_to(80);
        send_sample(80, 3, 1'b1, g1);
        send_sample(80, 8, 1'b1, g2);
        stream_to(91);
        wait_beats(2 * SPK_LEN, 2000, "backpressure");
        rand_ready = 1'b0;
        idle(5);
        expect_packet(3, 80, g1, "backpressure_a");
        expect_packet(8, 80, g2, "backpressure_b");
        n_checks++;
        if (stall_err !== 0) begin n_fail++; $display("FAIL backpressure stall changes got %0d exp 0", stall_err); end
        n_checks++;
        if (pulse_cnt !== 20) begin n_fail++; $display("FAIL backpressure pulses got %0d exp 20", pulse_cnt); end
    endtask

    task automatic test_stale();
        logic [31:0] g1, g2;
        g1 = {8'd2, 8'd3, 8'd4, 8'd5};
        g2 = {8'd4, 8'd5, 8'd6, 8'd7};
        ready_force = 1'b0;
        stream_to(100);
        send_sample(100, 2, 1'b1, g1);
        send_sample(100, 4, 1'b1, g2);
        stream_to(122);
        idle(3);
        n_checks++;
        if (spk_tvalid !== 1'b1 || spk_tframe !== 32'd100 || spk_tch !== 8'd2) begin
            n_fail++;
            $display("FAIL stale hold tvalid/tframe/tch got %b/%0d/%0d exp 1/100/2", spk_tvalid, spk_tframe, spk_tch);
        end
        n_checks++;
        if (q_beats.size() !== 0) begin n_fail++; $display("FAIL stale early beats got %0d exp 0", q_beats.size()); end
        ready_force = 1'b1;
        wait_beats(SPK_LEN, 400, "stale");
        expect_packet(2, 100, g1, "stale_first");
        idle(60);
        n_checks++;
        if (q_beats.size() !== 0) begin n_fail++; $display("FAIL stale second packet beats got %0d exp 0", q_beats.size()); end
        n_checks++;
        if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL stale drop_cnt got %0d exp 2", drop_cnt); end
        n_checks++;
        if (stall_err !== 0) begin n_fail++; $display("FAIL stale stall changes got %0d exp 0", stall_err); end
    endtask

    task automatic test_refractory();
        logic [31:0] g;
        int          npk;
`ifdef SPK_PACK_REFRACT_EN
        npk = 1;
`else
        npk = 2;
`endif
        g = {8'd9, 8'd8, 8'd7, 8'd6};
        stream_to(130);
        send_sample(130, 9, 1'b1, g);
        stream_to(140);
        send_sample(140, 9, 1'b1, g);
        stream_to(151);
        wait_beats(npk * SPK_LEN, 1000, "refractory");
        expect_packet(9, 130, g, "refractory_a");
        if (npk == 2) expect_packet(9, 140, g, "refractory_b");
        idle(60);
        n_checks++;
        if (q_beats.size() !== 0) begin n_fail++; $display("FAIL refractory extra beats got %0d exp 0", q_beats.size()); end
        n_checks++;
        if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL refractory drop_cnt got %0d exp 2", drop_cnt); end
        n_checks++;
        if (pulse_cnt !== 21 + npk) begin n_fail++; $display("FAIL refractory pulses got %0d exp %0d", pulse_cnt, 21 + npk); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_ramp();
        test_fifo_overflow();
        test_backpressure();
        test_stale();
        test_refractory();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
